// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared definitions for the fetch controller slice.
//   state_t   : 2-bit FSM encoding used by fetch_ctrl (BOOT, RUN, MEM_WAIT, HALT)
//   NOP_INSTR : the instruction word that a flushed IF/ID register holds (addi x0,x0,0)
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/fetch_ctrl_hazard_detect.sv
// hazard_detect
// Combinational load-use hazard detector for the ID stage.
// Ports:
//   mem_read  in  1  instruction in EX is a load
//   ex_rd     in  5  destination register of the instruction in EX
//   id_rs1    in  5  source register 1 of the instruction in ID
//   id_rs2    in  5  source register 2 of the instruction in ID
//   load_use  out 1  ID instruction needs the load result that is not ready yet
module hazard_detect
    import fetch_ctrl_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       load_use
);

    // x0 is hard-wired to zero, so a load targeting it can never cause a hazard.
    always_comb begin
        load_use = mem_read && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Fetch-stage controller: boot sequencing, load-use stalls, branch redirects,
// instruction-memory wait handling with a sticky timeout flag, and halt/resume.
// Optional build macro: FETCH_CTRL_PERF_EN adds the stall_cnt/flush_cnt counters.
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   branch_taken   in   EX-stage branch resolved taken
//   ID_EX_MemRead  in   EX instruction is a load
//   ID_EX_rd       in   EX destination register
//   IF_ID_rs1/rs2  in   ID source registers
//   imem_ready     in   instruction memory data valid this cycle
//   halt_req       in   request to freeze fetch
//   resume         in   leave HALT
//   PCSrc          out  select branch target into PC
//   PC_write       out  PC load enable
//   IF_ID_write    out  IF/ID load enable
//   IF_ID_flush    out  load NOP into IF/ID
//   ID_EX_flush    out  load bubble into ID/EX
//   halted         out  FSM is in HALT
//   mem_err        out  sticky instruction-memory timeout
//   stall_cnt      out  (FETCH_CTRL_PERF_EN) cycles with PC held in RUN/MEM_WAIT
//   flush_cnt      out  (FETCH_CTRL_PERF_EN) branch redirects taken
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES  = 2,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_rd,
    input  logic [4:0]  IF_ID_rs1,
    input  logic [4:0]  IF_ID_rs2,
    input  logic        imem_ready,
    input  logic        halt_req,
    input  logic        resume,
    output logic        PCSrc,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        halted,
    output logic        mem_err
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    state_t             state;
    state_t             state_next;
    logic [BOOT_W-1:0]  boot_cnt;
    logic [3:0]         wait_cnt;
    logic [3:0]         wait_cnt_next;
    logic               mem_err_q;
    logic               load_use;
    logic               boot_done;

    hazard_detect u_hazard_detect (
        .mem_read (ID_EX_MemRead),
        .ex_rd    (ID_EX_rd),
        .id_rs1   (IF_ID_rs1),
        .id_rs2   (IF_ID_rs2),
        .load_use (load_use)
    );

    assign boot_done = (boot_cnt == BOOT_W'(BOOT_CYCLES - 1));

    // Next-state and control decode. A branch redirect wins over stalls and
    // memory waits; halt_req only changes the next state so a coincident
    // redirect still completes. Reset forces the boot outputs immediately.
    always_comb begin
        state_next  = state;
        PCSrc       = 1'b0;
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;

        case (state)
            BOOT: begin
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
                if (boot_done) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (branch_taken) begin
                    PCSrc       = 1'b1;
                    PC_write    = 1'b1;
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                end else if (load_use) begin
                    ID_EX_flush = 1'b1;
                end else if (!imem_ready) begin
                    IF_ID_flush = 1'b1;
                    state_next  = MEM_WAIT;
                end else begin
                    PC_write    = 1'b1;
                    IF_ID_write = 1'b1;
                end
                if (halt_req) begin
                    state_next = HALT;
                end
            end
            MEM_WAIT: begin
                if (branch_taken) begin
                    PCSrc       = 1'b1;
                    PC_write    = 1'b1;
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                    state_next  = RUN;
                end else if (imem_ready) begin
                    PC_write    = 1'b1;
                    IF_ID_write = 1'b1;
                    state_next  = RUN;
                end else begin
                    IF_ID_flush = 1'b1;
                end
                if (halt_req) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                // ID/EX keeps flowing so instructions already issued drain out.
                IF_ID_flush = 1'b1;
                if (resume) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase

        if (reset) begin
            state_next  = BOOT;
            PCSrc       = 1'b0;
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end
    end

    // The wait counter tracks how long we have been stuck in MEM_WAIT,
    // saturating at 15 and dropping to zero as soon as MEM_WAIT is left.
    always_comb begin
        wait_cnt_next = 4'd0;
        if (state_next == MEM_WAIT) begin
            wait_cnt_next = (wait_cnt == 4'hF) ? 4'hF : wait_cnt + 4'd1;
        end
    end

    // State register plus boot/wait counters and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BOOT;
            boot_cnt  <= '0;
            wait_cnt  <= 4'd0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_next;
            boot_cnt  <= (state == BOOT) ? boot_cnt + BOOT_W'(1) : '0;
            wait_cnt  <= wait_cnt_next;
            if (wait_cnt_next == 4'(MEM_WAIT_MAX)) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    // Status outputs read the registered state; reset masks them right away.
    assign halted  = (state == HALT) && !reset;
    assign mem_err = mem_err_q && !reset;

`ifdef FETCH_CTRL_PERF_EN
    // Performance counters: held-PC cycles while fetching, and branch redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (((state == RUN) || (state == MEM_WAIT)) && !PC_write) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (((state == RUN) || (state == MEM_WAIT)) && branch_taken) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`else
    // Default build carries no performance counters.
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter BOOT_CYCLES, default 2: cycles after reset release with fetch held and pipeline registers flushed.
REQ-002 SHALL have parameter MEM_WAIT_MAX, default 15: maximum consecutive MEM_WAIT cycles before mem_err sets.
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- branch_taken  in  1  EX-stage branch resolved taken; PC_Branch valid this cycle.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_rd  in  5  destination register of the instruction in EX.
- IF_ID_rs1  in  5  source register 1 of the instruction in ID.
- IF_ID_rs2  in  5  source register 2 of the instruction in ID.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- halt_req  in  1  request to freeze fetch.
- resume  in  1  leave HALT.
- PCSrc  out  1  selects PC_Branch into PC.
- PC_write  out  1  PC load enable.
- IF_ID_write  out  1  IF/ID register load enable.
- IF_ID_flush  out  1  load NOP into IF/ID.
- ID_EX_flush  out  1  load bubble (zero controls) into ID/EX.
- halted  out  1  FSM in HALT.
- mem_err  out  1  sticky memory-timeout flag.

Function
REQ-004 SHALL implement FSM states BOOT, RUN, MEM_WAIT, HALT; reset enters BOOT.
REQ-005 In BOOT SHALL drive PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, PCSrc=0 for exactly BOOT_CYCLES cycles, then enter RUN.
REQ-006 SHALL define load_use = ID_EX_MemRead & (ID_EX_rd != 0) & ((ID_EX_rd == IF_ID_rs1) | (ID_EX_rd == IF_ID_rs2)), combinational.
REQ-007 In RUN/MEM_WAIT with branch_taken=1, SHALL drive PCSrc=1, PC_write=1, IF_ID_flush=1, ID_EX_flush=1, IF_ID_write=0 in the same cycle; branch SHALL override load_use and imem_ready.
REQ-008 In RUN with no branch and load_use=1, SHALL drive PC_write=0, IF_ID_write=0, ID_EX_flush=1 for that cycle only; state unchanged.
REQ-009 In RUN with no branch, no load_use and imem_ready=0, SHALL drive PC_write=0, IF_ID_write=0, IF_ID_flush=1 and enter MEM_WAIT next cycle.
REQ-010 In MEM_WAIT SHALL hold the outputs of REQ-009 until imem_ready=1, then drive PC_write=1 and IF_ID_write=1 that cycle and return to RUN.
REQ-011 SHALL count consecutive MEM_WAIT cycles with a 4-bit saturating counter cleared on leaving MEM_WAIT; at count == MEM_WAIT_MAX, mem_err SHALL set and stay set until reset.
REQ-012 Otherwise in RUN, SHALL drive PC_write=1, IF_ID_write=1, all flushes 0, PCSrc=0.
REQ-013 halt_req=1 in RUN or MEM_WAIT SHALL enter HALT next cycle; a same-cycle branch_taken redirect SHALL still complete.
REQ-014 In HALT SHALL drive PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=0, PCSrc=0, halted=1, so the pipeline drains; resume=1 SHALL return to RUN next cycle; halt_req is ignored in HALT.
REQ-015 halted SHALL be registered state decode; all other control outputs are combinational from state and inputs.

Reset
REQ-016 Reset SHALL be sampled on rising clk only and override all inputs.
REQ-017 While reset=1 and in the first BOOT cycle after it, outputs SHALL be PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, PCSrc=0, halted=0, mem_err=0, with counters cleared; reset mid-MEM_WAIT or mid-HALT SHALL behave identically.

Configuration
REQ-018 Macro FETCH_CTRL_PERF_EN SHALL add outputs stall_cnt[31:0] (cycles with PC_write=0 in RUN/MEM_WAIT) and flush_cnt[31:0] (branch redirects), both wrapping, reset to 0; without the macro these ports and counters SHALL NOT exist and behaviour is otherwise identical.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding (2-bit) and the NOP instruction constant 32'h00000013.
REQ-020 One sub-module, hazard_detect, SHALL compute load_use combinationally; all other logic SHALL be in fetch_ctrl.

Verification
REQ-021 Reset 1 cycle, then idle with imem_ready=1: flushes=1 for 2 cycles, then PC_write=1, IF_ID_write=1.
REQ-022 ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5: one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1; with ID_EX_rd=0: no stall.
REQ-023 branch_taken=1 coincident with load_use=1: PCSrc=1, PC_write=1, both flushes=1.
REQ-024 imem_ready=0 for 3 cycles: 3 stall cycles, 1 MEM_WAIT transition, resume on ready; held low for 16 cycles: mem_err=1 and sticky.
REQ-025 halt_req pulse in RUN: halted=1 next cycle, PC_write=0; resume pulse: RUN next cycle; reset asserted while halted: returns to BOOT with halted=0.
